mem_stage: RTL and testbench

Memory-access stage of the MINAv2 pipeline, between the EX/MEM register and the MEM/WB register. It passes ALU results through and performs byte, half and word loads and stores on a single-outstanding req/ack data bus. It stalls the upstream pipeline while an access is in flight. It drives a `types::wb_params_t` (`rd_addr`, `rd_data`) into MEM/WB, with `rd_addr == '0` encoding "no write / bubble".

---
 rtl/mem_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MINAv2 memory-access stage: ALU pass-through plus byte/half/word loads and stores on a req/ack bus.
package types;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [31:0]           rd_data;
  } wb_params_t;
endpackage

module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_in,
  input  logic [1:0]                  mem_op,
  input  logic [1:0]                  mem_size,
  input  logic                        load_signed,
  input  logic [31:0]                 addr,
  input  logic [31:0]                 store_data,
  input  logic [31:0]                 alu_result,
  input  logic [types::REG_ADDR_W-1:0] rd_addr,
  output logic                        stall,
  output logic                        err_misaligned,
  output logic                        err_bus,
  output logic                        bus_req,
  output logic                        bus_we,
  output logic [31:0]                 bus_addr,
  output logic [31:0]                 bus_wdata,
  output logic [3:0]                  bus_be,
  input  logic                        bus_ack,
  input  logic [31:0]                 bus_rdata,
  output types::wb_params_t           wb_params_out
);

  // A zero TIMEOUT_CYCLES still needs a one-bit counter to keep the logic legal.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit WATCHDOG_ON = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                       state;
  logic [CNT_W-1:0]             wd_cnt;
  logic [types::REG_ADDR_W-1:0] rd_lat;
  logic [1:0]                   size_lat;
  logic [1:0]                   off_lat;
  logic                         sign_lat;
  logic                         abort;
  logic [31:0]                  load_data;

  logic        is_mem;
  logic        misaligned;
  logic        start;
  logic        timeout_hit;
  logic [31:0] wdata_next;
  logic [3:0]  be_next;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  assign is_mem = valid_in && (mem_op == 2'b01 || mem_op == 2'b10);

  always_comb begin
    misaligned = 1'b0;
    wdata_next = store_data;
    be_next    = 4'b1111;
    case (mem_size)
      2'b00: begin
        wdata_next = {4{store_data[7:0]}};
        be_next    = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        misaligned = addr[0];
        wdata_next = {2{store_data[15:0]}};
        be_next    = 4'b0011 << addr[1:0];
      end
      default: misaligned = |addr[1:0];
    endcase
  end

  assign start       = (state == IDLE) && is_mem && !misaligned;
  assign timeout_hit = WATCHDOG_ON && (wd_cnt == CNT_LAST);

  // Bring the addressed lane down to bit 0, then extend from the access width.
  assign shifted = bus_rdata >> {off_lat, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (size_lat)
      2'b00:   load_ext = {{24{sign_lat & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{sign_lat & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  assign stall          = start || (state == BUSY);
  assign err_misaligned = (state == IDLE) && is_mem && misaligned;
  assign err_bus        = (state == DONE) && abort;

  always_comb begin
    wb_params_out = '0;
    if (state == IDLE && !is_mem) begin
      wb_params_out.rd_addr = valid_in ? rd_addr : '0;
      wb_params_out.rd_data = alu_result;
    end else if (state == DONE && !bus_we && !abort) begin
      wb_params_out.rd_addr = rd_lat;
      wb_params_out.rd_data = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      load_data <= '0;
      wd_cnt    <= '0;
      abort     <= 1'b0;
      rd_lat    <= '0;
      size_lat  <= '0;
      off_lat   <= '0;
      sign_lat  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= BUSY;
            bus_req   <= 1'b1;
            bus_we    <= (mem_op == 2'b10);
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wdata <= wdata_next;
            bus_be    <= be_next;
            rd_lat    <= rd_addr;
            size_lat  <= mem_size;
            off_lat   <= addr[1:0];
            sign_lat  <= load_signed;
            wd_cnt    <= '0;
            abort     <= 1'b0;
          end
        end
        BUSY: begin
          if (bus_ack) begin
            state     <= DONE;
            bus_req   <= 1'b0;
            load_data <= load_ext;
          end else if (timeout_hit) begin
            state   <= DONE;
            bus_req <= 1'b0;
            abort   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against a lane-level reference model.
module tb_mem_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [1:0]  mem_op;
  logic [1:0]  mem_size;
  logic        load_signed;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] alu_result;
  logic [4:0]  rd_addr;
  logic        stall;
  logic        err_misaligned;
  logic        err_bus;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  types::wb_params_t wb_params_out;

  int checks = 0;
  int errors = 0;

  mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mem_op(mem_op),
    .mem_size(mem_size), .load_signed(load_signed), .addr(addr),
    .store_data(store_data), .alu_result(alu_result), .rd_addr(rd_addr),
    .stall(stall), .err_misaligned(err_misaligned), .err_bus(err_bus),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .wb_params_out(wb_params_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Byte-lane view of the bus: lane i carries byte (i mod n) of the store source.
  function automatic logic [31:0] exp_wdata(input logic [31:0] sd, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] exp_be(input int off, input int n);
    logic [3:0] r = '0;
    for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + n);
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rd, input int off, input int n, input logic sgn);
    longint v = 0;
    for (int j = 0; j < n; j++) v += longint'(rd[8*(off+j) +: 8]) << (8*j);
    if (sgn && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    valid_in = 1'b0; mem_op = 2'b00; mem_size = 2'b00; load_signed = 1'b0;
    addr = '0; store_data = '0; alu_result = '0; rd_addr = '0;
  endtask

  // Starts #1 after a posedge, ends #1 after a posedge. wait_n = BUSY cycles before ack.
  task automatic do_access(input logic v, input logic [1:0] op, input logic [1:0] sz, input logic sgn,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] alu,
                           input logic [4:0] rd, input logic [31:0] rdt, input int wait_n);
    int n, off;
    logic mem, mis, aborted;
    logic [36:0] exp_wb;
    valid_in = v; mem_op = op; mem_size = sz; load_signed = sgn; addr = a;
    store_data = sd; alu_result = alu; rd_addr = rd; bus_ack = 1'b0;
    n = nbytes(sz); off = int'(a[1:0]);
    mem = v && (op == 2'b01 || op == 2'b10);
    mis = (off % n) != 0;
    @(negedge clk);
    if (!mem) begin
      chk("alu_wb", 64'(wb_params_out), 64'({(v ? rd : 5'd0), alu}));
      chk("alu_stall", 64'(stall), 64'(0));
      chk("alu_req", 64'(bus_req), 64'(0));
      @(posedge clk); #1;
      return;
    end
    if (mis) begin
      chk("mis_err", 64'(err_misaligned), 64'(1));
      chk("mis_stall", 64'(stall), 64'(0));
      chk("mis_wb", 64'(wb_params_out), 64'(0));
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("mis_pulse_end", 64'(err_misaligned), 64'(0));
      chk("mis_no_req", 64'(bus_req), 64'(0));
      @(posedge clk); #1;
      return;
    end
    chk("issue_stall", 64'(stall), 64'(1));
    chk("issue_wb", 64'(wb_params_out), 64'(0));
    chk("issue_err", 64'(err_misaligned), 64'(0));
    @(posedge clk); #1;
    aborted = 1'b1;
    for (int k = 0; k < T; k++) begin
      bus_ack = (k == wait_n);
      bus_rdata = (k == wait_n) ? rdt : $urandom;
      @(negedge clk);
      chk("busy_req", 64'(bus_req), 64'(1));
      chk("busy_stall", 64'(stall), 64'(1));
      chk("busy_wb", 64'(wb_params_out), 64'(0));
      chk("busy_addr", 64'(bus_addr), 64'({a[31:2], 2'b00}));
      chk("busy_we", 64'(bus_we), 64'(op == 2'b10));
      chk("busy_be", 64'(bus_be), 64'(exp_be(off, n)));
      chk("busy_wdata", 64'(bus_wdata), 64'(exp_wdata(sd, n)));
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (k == wait_n) begin
        aborted = 1'b0;
        break;
      end
    end
    exp_wb = (op == 2'b01 && !aborted) ? {rd, exp_load(rdt, off, n, sgn)} : 37'd0;
    @(negedge clk);
    chk("done_stall", 64'(stall), 64'(0));
    chk("done_req", 64'(bus_req), 64'(0));
    chk("done_err_bus", 64'(err_bus), 64'(aborted));
    chk("done_wb", 64'(wb_params_out), 64'(exp_wb));
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("post_err_bus", 64'(err_bus), 64'(0));
    chk("post_stall", 64'(stall), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    bus_ack = 1'b0; bus_rdata = '0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req", 64'(bus_req), 64'(0));
    chk("rst_we", 64'(bus_we), 64'(0));
    chk("rst_addr", 64'(bus_addr), 64'(0));
    chk("rst_wdata", 64'(bus_wdata), 64'(0));
    chk("rst_be", 64'(bus_be), 64'(0));
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_errs", 64'({err_bus, err_misaligned}), 64'(0));
    @(posedge clk); #1;

    do_access(1, 2'b00, 2'b10, 0, 32'h0, 32'h0, 32'h1234, 5'd3, 32'h0, 0);
    do_access(1, 2'b01, 2'b00, 1, 32'h1003, 32'h0, 32'h0, 5'd7, 32'h80FF_0000, 0);
    do_access(1, 2'b10, 2'b01, 0, 32'h2002, 32'hAAAA_BEEF, 32'h0, 5'd0, 32'h0, 2);
    do_access(1, 2'b01, 2'b10, 0, 32'h2001, 32'h0, 32'h0, 5'd9, 32'h0, 0);
    do_access(1, 2'b01, 2'b10, 0, 32'h3000, 32'h0, 32'h0, 5'd4, 32'hDEAD_BEEF, 99);
    do_access(1, 2'b01, 2'b10, 0, 32'h3000, 32'h0, 32'h0, 5'd4, 32'hDEAD_BEEF, T - 1);

    // Reset landing in the second BUSY cycle.
    do_access(1, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h55, 5'd1, 32'h0, 0);
    valid_in = 1'b1; mem_op = 2'b01; mem_size = 2'b10; addr = 32'h4000; rd_addr = 5'd12;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_req", 64'(bus_req), 64'(0));
    chk("rst_mid_stall", 64'(stall), 64'(0));
    chk("rst_mid_wb", 64'(wb_params_out), 64'(0));
    chk("rst_mid_err", 64'({err_bus, err_misaligned}), 64'(0));
    @(posedge clk); #1;

    for (int i = 0; i < 200; i++) begin
      do_access($urandom_range(0, 9) != 0, 2'($urandom), 2'($urandom), 1'($urandom),
                $urandom, $urandom, $urandom, 5'($urandom), $urandom, $urandom_range(0, 5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
